// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
//
// Shared definitions for the multicycle MIPS-subset control unit: the FSM
// state encoding, opcode/funct constants, ALU operation codes, ALU B-operand
// selector codes, PC source codes and the bundle of control outputs.
//
// Configuration macro: OVERFLOW_EXC_EN
//   When defined, the exception state ST_EXC exists and arithmetic overflow
//   or an undefined opcode traps to the exception vector.
// ----------------------------------------------------------------------------
package ctrl_pkg;

  // Cycles between presenting a memory address and having valid read data.
  localparam int MEM_WAIT_DEFAULT = 2;

  // FSM states. ST_FETCH and ST_MEM_RD are the counted memory-wait states,
  // ST_FETCH_LAST and ST_MEM_RD_LAST are the cycles where data is captured.
  typedef enum logic [3:0] {
    ST_RESET,
    ST_FETCH,
    ST_FETCH_LAST,
    ST_DECODE,
    ST_EXEC_R,
    ST_EXEC_I,
    ST_ALU_WB,
    ST_ADDR,
    ST_MEM_WR,
    ST_MEM_RD,
    ST_MEM_RD_LAST,
    ST_LW_WB,
    ST_BRANCH,
    ST_JUMP
`ifdef OVERFLOW_EXC_EN
    , ST_EXC
`endif
  } state_t;

  // Opcodes (IR[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0]).
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  // ALU operation codes.
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;

  // ALU B-operand selector.
  localparam logic [1:0] SRC_B_REG      = 2'b00;
  localparam logic [1:0] SRC_B_FOUR     = 2'b01;
  localparam logic [1:0] SRC_B_SEXT     = 2'b10;
  localparam logic [1:0] SRC_B_SEXT_SH2 = 2'b11;

  // PC source selector.
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_EXC    = 2'b11;

  // Every datapath control the FSM drives, kept together so the whole set
  // can be registered in one place.
  typedef struct packed {
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       mem_wr;
    logic       i_or_d;
    logic       ir_write;
    logic       ab_load;
    logic       alu_out_load;
    logic       mdr_load;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       epc_write;
  } ctrl_out_t;

  // True for the R-type operations that can overflow (signed add/sub).
  function automatic logic is_arith_funct(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB);
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// ----------------------------------------------------------------------------
// alu_op_decoder
//
// Combinational translation of an R-type funct field into the ALU operation
// code used during the R-type execute cycle. Unrecognised funct values fall
// back to ADD.
//
// Ports:
//   funct   in  6  IR[5:0]
//   alu_op  out 3  ALU operation code (see ctrl_pkg ALU_*)
// ----------------------------------------------------------------------------
module alu_op_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op
);

  // Straight lookup; ADD is the safe default for unsupported functs.
  always_comb begin
    alu_op = ALU_ADD;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
//
// Moore-style control FSM for the multicycle MIPS-subset datapath. Sequences
// fetch, decode, execute, memory and writeback, and drives every datapath
// mux select and load enable. Outputs are registered; the only combinational
// terms are pc_write in BRANCH (taken when zero=1) and, with the exception
// feature, the overflow suppression of reg_write in ALU_WB.
//
// Parameters:
//   MEM_WAIT  cycles between memory address presentation and valid read data
//
// Configuration macro: OVERFLOW_EXC_EN
//   Defined   : add/sub/addi overflow in ALU_WB suppresses the register write
//               and traps to EXC; undefined opcodes also trap to EXC.
//   Undefined : overflow is ignored, epc_write stays 0, no EXC state.
//
// Ports:
//   clk           in  1  system clock, rising edge
//   reset         in  1  synchronous active-high reset
//   opcode        in  6  IR[31:26]
//   funct         in  6  IR[5:0]
//   zero          in  1  ALU zero flag
//   overflow      in  1  ALU overflow flag
//   alu_src_a     out 1  0=PC, 1=A
//   alu_src_b     out 2  00=B, 01=4, 10=sext imm, 11=sext imm<<2
//   alu_op        out 3  001=ADD, 010=SUB, 011=AND, 000=pass A
//   pc_write      out 1  load PC
//   pc_source     out 2  00=ALU, 01=ALUOut, 10=jump target, 11=exc vector
//   mem_wr        out 1  memory write strobe
//   i_or_d        out 1  memory address: 0=PC, 1=ALUOut
//   ir_write      out 1  load IR
//   ab_load       out 1  load A and B
//   alu_out_load  out 1  load ALUOut
//   mdr_load      out 1  load MDR
//   reg_write     out 1  register file write
//   reg_dst       out 1  0=rt, 1=rd
//   mem_to_reg    out 1  0=ALUOut, 1=MDR
//   epc_write     out 1  load EPC
// ----------------------------------------------------------------------------
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT = MEM_WAIT_DEFAULT
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       mem_wr,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       ab_load,
  output logic       alu_out_load,
  output logic       mdr_load,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       epc_write
);

  // The wait counter only needs to reach MEM_WAIT-1.
  localparam int CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  ctrl_out_t        outs_q;
  ctrl_out_t        outs_nxt;
  logic [2:0]       r_alu_op;
  logic             ovf_trap;

  alu_op_decoder u_alu_op_decoder (
    .funct  (funct),
    .alu_op (r_alu_op)
  );

`ifdef OVERFLOW_EXC_EN
  // Remembers whether the instruction now in ALU_WB is one that may trap.
  logic ovf_check_q;
  assign ovf_trap = (state == ST_ALU_WB) && ovf_check_q && overflow;
`else
  logic unused_overflow;
  assign unused_overflow = overflow;
  assign ovf_trap        = 1'b0;
`endif

  // Control values for the cycle spent in state 'nxt'. 'cur' is the state
  // being left, which tells ALU_WB whether it came from an R-type or an
  // immediate execute and therefore which register field is the target.
  function automatic ctrl_out_t decode_outputs(input state_t     nxt,
                                               input state_t     cur,
                                               input logic [2:0] r_op);
    ctrl_out_t o;
    o        = '0;
    o.alu_op = ALU_PASS;
    case (nxt)
      ST_FETCH_LAST: begin
        o.ir_write  = 1'b1;
        o.alu_src_a = 1'b0;
        o.alu_src_b = SRC_B_FOUR;
        o.alu_op    = ALU_ADD;
        o.pc_source = PC_SRC_ALU;
        o.pc_write  = 1'b1;
      end
      ST_DECODE: begin
        o.ab_load      = 1'b1;
        o.alu_src_a    = 1'b0;
        o.alu_src_b    = SRC_B_SEXT_SH2;
        o.alu_op       = ALU_ADD;
        o.alu_out_load = 1'b1;
      end
      ST_EXEC_R: begin
        o.alu_src_a    = 1'b1;
        o.alu_src_b    = SRC_B_REG;
        o.alu_op       = r_op;
        o.alu_out_load = 1'b1;
      end
      ST_EXEC_I, ST_ADDR: begin
        o.alu_src_a    = 1'b1;
        o.alu_src_b    = SRC_B_SEXT;
        o.alu_op       = ALU_ADD;
        o.alu_out_load = 1'b1;
      end
      ST_ALU_WB: begin
        o.reg_write  = 1'b1;
        o.mem_to_reg = 1'b0;
        o.reg_dst    = (cur == ST_EXEC_R);
      end
      ST_MEM_WR: begin
        o.i_or_d = 1'b1;
        o.mem_wr = 1'b1;
      end
      ST_MEM_RD: begin
        o.i_or_d = 1'b1;
      end
      ST_MEM_RD_LAST: begin
        o.i_or_d   = 1'b1;
        o.mdr_load = 1'b1;
      end
      ST_LW_WB: begin
        o.reg_write  = 1'b1;
        o.mem_to_reg = 1'b1;
        o.reg_dst    = 1'b0;
      end
      ST_BRANCH: begin
        // pc_write is added combinationally from the zero flag.
        o.alu_src_a = 1'b1;
        o.alu_src_b = SRC_B_REG;
        o.alu_op    = ALU_SUB;
        o.pc_source = PC_SRC_ALUOUT;
      end
      ST_JUMP: begin
        o.pc_source = PC_SRC_JUMP;
        o.pc_write  = 1'b1;
      end
`ifdef OVERFLOW_EXC_EN
      ST_EXC: begin
        o.epc_write = 1'b1;
        o.pc_source = PC_SRC_EXC;
        o.pc_write  = 1'b1;
      end
`endif
      default: o = '0;
    endcase
    return o;
  endfunction

  // Next-state logic. The memory-wait states hold until the counter reaches
  // its last value; everything else advances every cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET:      state_nxt = ST_FETCH;
      ST_FETCH:      state_nxt = (wait_cnt == CNT_LAST) ? ST_FETCH_LAST : ST_FETCH;
      ST_FETCH_LAST: state_nxt = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_nxt = ST_EXEC_R;
          OP_ADDI:      state_nxt = ST_EXEC_I;
          OP_LW, OP_SW: state_nxt = ST_ADDR;
          OP_BEQ:       state_nxt = ST_BRANCH;
          OP_J:         state_nxt = ST_JUMP;
`ifdef OVERFLOW_EXC_EN
          default:      state_nxt = ST_EXC;
`else
          default:      state_nxt = ST_FETCH;
`endif
        endcase
      end
      ST_EXEC_R:     state_nxt = ST_ALU_WB;
      ST_EXEC_I:     state_nxt = ST_ALU_WB;
`ifdef OVERFLOW_EXC_EN
      ST_ALU_WB:     state_nxt = ovf_trap ? ST_EXC : ST_FETCH;
      ST_EXC:        state_nxt = ST_FETCH;
`else
      ST_ALU_WB:     state_nxt = ST_FETCH;
`endif
      ST_ADDR:       state_nxt = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_WR:     state_nxt = ST_FETCH;
      ST_MEM_RD:     state_nxt = (wait_cnt == CNT_LAST) ? ST_MEM_RD_LAST : ST_MEM_RD;
      ST_MEM_RD_LAST: state_nxt = ST_LW_WB;
      ST_LW_WB:      state_nxt = ST_FETCH;
      ST_BRANCH:     state_nxt = ST_FETCH;
      ST_JUMP:       state_nxt = ST_FETCH;
      default:       state_nxt = ST_RESET;
    endcase
  end

  // Output values for the upcoming state, captured on the same edge as the
  // state itself so that outputs never glitch through decode logic.
  always_comb begin
    outs_nxt = decode_outputs(state_nxt, state, r_alu_op);
  end

  // State, wait counter and registered outputs. Reset clears all outputs so
  // no write strobe can fire in the cycle after reset is seen. The counter
  // restarts at zero whenever the state changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RESET;
      wait_cnt <= '0;
      outs_q   <= '0;
`ifdef OVERFLOW_EXC_EN
      ovf_check_q <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state_nxt != state) ? '0 : wait_cnt + CNT_W'(1);
      outs_q   <= outs_nxt;
`ifdef OVERFLOW_EXC_EN
      ovf_check_q <= ((state == ST_EXEC_R) && is_arith_funct(funct)) ||
                     (state == ST_EXEC_I);
`endif
    end
  end

  assign alu_src_a    = outs_q.alu_src_a;
  assign alu_src_b    = outs_q.alu_src_b;
  assign alu_op       = outs_q.alu_op;
  assign pc_write     = outs_q.pc_write | ((state == ST_BRANCH) && zero);
  assign pc_source    = outs_q.pc_source;
  assign mem_wr       = outs_q.mem_wr;
  assign i_or_d       = outs_q.i_or_d;
  assign ir_write     = outs_q.ir_write;
  assign ab_load      = outs_q.ab_load;
  assign alu_out_load = outs_q.alu_out_load;
  assign mdr_load     = outs_q.mdr_load;
  assign reg_write    = outs_q.reg_write & ~ovf_trap;
  assign reg_dst      = outs_q.reg_dst;
  assign mem_to_reg   = outs_q.mem_to_reg;
  // Only the EXC state ever sets this field, so it is constant 0 without
  // the exception feature.
  assign epc_write    = outs_q.epc_write;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl. Each stimulus call drives the inputs for
// one clock cycle and queues the control word expected during that cycle; a
// separate monitor pops the queue at every falling edge and compares.
// Build with +define+OVERFLOW_EXC_EN to check the exception variant.
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       mem_wr;
    logic       i_or_d;
    logic       ir_write;
    logic       ab_load;
    logic       alu_out_load;
    logic       mdr_load;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       epc_write;
  } out_t;

`ifdef OVERFLOW_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       overflow = 1'b0;

  logic       alu_src_a, pc_write, mem_wr, i_or_d, ir_write, ab_load;
  logic       alu_out_load, mdr_load, reg_write, reg_dst, mem_to_reg, epc_write;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;

  out_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  multicycle_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .funct        (funct),
    .zero         (zero),
    .overflow     (overflow),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .pc_write     (pc_write),
    .pc_source    (pc_source),
    .mem_wr       (mem_wr),
    .i_or_d       (i_or_d),
    .ir_write     (ir_write),
    .ab_load      (ab_load),
    .alu_out_load (alu_out_load),
    .mdr_load     (mdr_load),
    .reg_write    (reg_write),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .epc_write    (epc_write)
  );

  always #5 clk = ~clk;

  // Expected control words, written out by hand per state.
  function automatic out_t o_idle();
    out_t o = '0;
    return o;
  endfunction

  function automatic out_t o_fetch_last();
    out_t o = '0;
    o.ir_write = 1'b1; o.alu_src_b = 2'b01; o.alu_op = 3'b001; o.pc_write = 1'b1;
    return o;
  endfunction

  function automatic out_t o_decode();
    out_t o = '0;
    o.ab_load = 1'b1; o.alu_src_b = 2'b11; o.alu_op = 3'b001; o.alu_out_load = 1'b1;
    return o;
  endfunction

  function automatic out_t o_exec_r(input logic [2:0] op);
    out_t o = '0;
    o.alu_src_a = 1'b1; o.alu_src_b = 2'b00; o.alu_op = op; o.alu_out_load = 1'b1;
    return o;
  endfunction

  function automatic out_t o_exec_imm();
    out_t o = '0;
    o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 3'b001; o.alu_out_load = 1'b1;
    return o;
  endfunction

  function automatic out_t o_alu_wb(input logic rw, input logic rd);
    out_t o = '0;
    o.reg_write = rw; o.reg_dst = rd;
    return o;
  endfunction

  function automatic out_t o_mem(input logic wr, input logic mdr);
    out_t o = '0;
    o.i_or_d = 1'b1; o.mem_wr = wr; o.mdr_load = mdr;
    return o;
  endfunction

  function automatic out_t o_lw_wb();
    out_t o = '0;
    o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
    return o;
  endfunction

  function automatic out_t o_branch(input logic z);
    out_t o = '0;
    o.alu_src_a = 1'b1; o.alu_op = 3'b010; o.pc_source = 2'b01; o.pc_write = z;
    return o;
  endfunction

  function automatic out_t o_jump();
    out_t o = '0;
    o.pc_source = 2'b10; o.pc_write = 1'b1;
    return o;
  endfunction

  function automatic out_t o_exc();
    out_t o = '0;
    o.epc_write = 1'b1; o.pc_source = 2'b11; o.pc_write = 1'b1;
    return o;
  endfunction

  function automatic out_t sample_dut();
    out_t o;
    o = {alu_src_a, alu_src_b, alu_op, pc_write, pc_source, mem_wr, i_or_d,
         ir_write, ab_load, alu_out_load, mdr_load, reg_write, reg_dst,
         mem_to_reg, epc_write};
    return o;
  endfunction

  // Drive one cycle of inputs and queue the control word expected in it.
  task automatic applyStimulus(input logic rst, input logic [5:0] op,
                               input logic [5:0] fn, input logic z,
                               input logic ov, input out_t exp, input string nm);
    @(posedge clk);
    #1;
    reset    = rst;
    opcode   = op;
    funct    = fn;
    zero     = z;
    overflow = ov;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  task automatic checkOutput(input string nm, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic fetch(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input string tag);
    applyStimulus(1'b0, op, fn, z, 1'b0, o_idle(),       {tag, ":fetch0"});
    applyStimulus(1'b0, op, fn, z, 1'b0, o_idle(),       {tag, ":fetch1"});
    applyStimulus(1'b0, op, fn, z, 1'b0, o_fetch_last(), {tag, ":fetch_last"});
  endtask

  // R-type: 6 cycles, or 7 when the writeback traps.
  task automatic run_r(input logic [5:0] fn, input logic [2:0] op,
                       input logic ov, input logic trap, input string tag);
    fetch(6'h00, fn, 1'b0, tag);
    applyStimulus(1'b0, 6'h00, fn, 1'b0, 1'b0, o_decode(),      {tag, ":decode"});
    applyStimulus(1'b0, 6'h00, fn, 1'b0, 1'b0, o_exec_r(op),    {tag, ":exec_r"});
    applyStimulus(1'b0, 6'h00, fn, 1'b0, ov,   o_alu_wb(!trap, 1'b1), {tag, ":alu_wb"});
    if (trap)
      applyStimulus(1'b0, 6'h00, fn, 1'b0, 1'b0, o_exc(), {tag, ":exc"});
  endtask

  task automatic run_addi(input logic ov, input logic trap, input string tag);
    fetch(6'h08, 6'h00, 1'b0, tag);
    applyStimulus(1'b0, 6'h08, 6'h00, 1'b0, 1'b0, o_decode(),   {tag, ":decode"});
    applyStimulus(1'b0, 6'h08, 6'h00, 1'b0, 1'b0, o_exec_imm(), {tag, ":exec_i"});
    applyStimulus(1'b0, 6'h08, 6'h00, 1'b0, ov,   o_alu_wb(!trap, 1'b0), {tag, ":alu_wb"});
    if (trap)
      applyStimulus(1'b0, 6'h08, 6'h00, 1'b0, 1'b0, o_exc(), {tag, ":exc"});
  endtask

  task automatic run_lw(input string tag);
    fetch(6'h23, 6'h00, 1'b0, tag);
    applyStimulus(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, o_decode(),         {tag, ":decode"});
    applyStimulus(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, o_exec_imm(),       {tag, ":addr"});
    applyStimulus(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, o_mem(1'b0, 1'b0),  {tag, ":mem_rd0"});
    applyStimulus(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, o_mem(1'b0, 1'b0),  {tag, ":mem_rd1"});
    applyStimulus(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, o_mem(1'b0, 1'b1),  {tag, ":mdr_load"});
    applyStimulus(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, o_lw_wb(),          {tag, ":lw_wb"});
  endtask

  task automatic run_sw(input string tag);
    fetch(6'h2B, 6'h00, 1'b0, tag);
    applyStimulus(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, o_decode(),        {tag, ":decode"});
    applyStimulus(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, o_exec_imm(),      {tag, ":addr"});
    applyStimulus(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, o_mem(1'b1, 1'b0), {tag, ":mem_wr"});
  endtask

  // zero is held high through the whole taken branch to show it only
  // matters in the BRANCH cycle.
  task automatic run_beq(input logic z, input string tag);
    fetch(6'h04, 6'h00, z, tag);
    applyStimulus(1'b0, 6'h04, 6'h00, z, 1'b0, o_decode(),  {tag, ":decode"});
    applyStimulus(1'b0, 6'h04, 6'h00, z, 1'b0, o_branch(z), {tag, ":branch"});
  endtask

  task automatic run_j(input string tag);
    fetch(6'h02, 6'h00, 1'b0, tag);
    applyStimulus(1'b0, 6'h02, 6'h00, 1'b0, 1'b0, o_decode(), {tag, ":decode"});
    applyStimulus(1'b0, 6'h02, 6'h00, 1'b0, 1'b0, o_jump(),   {tag, ":jump"});
  endtask

  task automatic run_undef(input string tag);
    fetch(6'h3F, 6'h00, 1'b0, tag);
    applyStimulus(1'b0, 6'h3F, 6'h00, 1'b0, 1'b0, o_decode(), {tag, ":decode"});
`ifdef OVERFLOW_EXC_EN
    applyStimulus(1'b0, 6'h3F, 6'h00, 1'b0, 1'b0, o_exc(), {tag, ":exc"});
`endif
  endtask

  // Reset held for three edges while a load sits in MEM_RD.
  task automatic run_reset_mid_lw(input string tag);
    fetch(6'h23, 6'h00, 1'b0, tag);
    applyStimulus(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, o_decode(),        {tag, ":decode"});
    applyStimulus(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, o_exec_imm(),      {tag, ":addr"});
    applyStimulus(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, o_mem(1'b0, 1'b0), {tag, ":mem_rd0"});
    applyStimulus(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, o_idle(),          {tag, ":held1"});
    applyStimulus(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, o_idle(),          {tag, ":held2"});
    applyStimulus(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, o_idle(),          {tag, ":held3"});
  endtask

  // Monitor: compare the live control word against the queue every cycle.
  initial begin
    out_t  e;
    string n;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checkOutput(n, sample_dut(), e);
      end
    end
  end

  // Stimulus sequence.
  initial begin
    $display("[TB] multicycle_ctrl bench, exception feature = %0d", EXC_EN);
    applyStimulus(1'b1, 6'h00, 6'h00, 1'b0, 1'b0, o_idle(), "reset0");
    applyStimulus(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, o_idle(), "reset1");

    run_r(6'h22, 3'b010, 1'b0, 1'b0, "sub");
    run_r(6'h24, 3'b011, 1'b0, 1'b0, "and");
    run_r(6'h25, 3'b001, 1'b0, 1'b0, "r_default");
    run_addi(1'b0, 1'b0, "addi");
    run_sw("sw");
    run_lw("lw");
    run_beq(1'b1, "beq_taken");
    run_beq(1'b0, "beq_not_taken");
    run_j("jump");
    run_undef("undef_3f");
    run_addi(1'b1, EXC_EN, "addi_ovf");
    run_r(6'h20, 3'b001, 1'b1, EXC_EN, "add_ovf");
    run_r(6'h24, 3'b011, 1'b1, 1'b0, "and_ovf_ignored");
    run_reset_mid_lw("rst_mid_lw");
    run_r(6'h20, 3'b001, 1'b0, 1'b0, "add_after_reset");

    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL timeout: got running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore-style control FSM for the multicycle MIPS-subset datapath.
- Sequences instruction fetch, decode, execute, memory and writeback.
- Drives the ALU operand selectors: A-source, and the 2-bit B-source choosing B register, constant 4, sign-extended immediate, or sign-extended immediate shifted left 2.
- Also drives ALU op, PC, IR, memory and register-file enables.
- Sits between the instruction register fields and every datapath mux/enable.

Parameters:
MEM_WAIT, 2, cycles between memory address presentation and valid read data (fetch and lw).

Ports:
clk  in  1  system clock, all state changes on rising edge
reset  in  1  synchronous, active-high reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
overflow  in  1  ALU overflow flag
alu_src_a  out  1  0=PC, 1=A register
alu_src_b  out  2  00=B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  out  3  001=ADD, 010=SUB, 011=AND, 000=pass A
pc_write  out  1  load PC
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=exception vector
mem_wr  out  1  memory write strobe (0=read)
i_or_d  out  1  memory address: 0=PC, 1=ALUOut
ir_write  out  1  load IR
ab_load  out  1  load A and B registers
alu_out_load  out  1  load ALUOut
mdr_load  out  1  load memory data register
reg_write  out  1  register file write
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUOut, 1=MDR
epc_write  out  1  load EPC

Behaviour:
- Reset: while reset=1 at a rising edge, state<=ST_RESET. In ST_RESET all outputs are 0, including alu_src_b=00 and alu_op=000. The first edge with reset=0 moves to FETCH_0.
- Reset is honoured in any state and aborts the instruction in flight. No write strobe may assert in the cycle after reset is sampled.
- Outputs are a function of state only, except pc_write in BRANCH (depends on zero) and reg_write in ALU_WB (depends on overflow when the optional feature is on).
- FETCH_0..FETCH_(MEM_WAIT): i_or_d=0, mem_wr=0. The wait counter counts 0..MEM_WAIT-1, then goes to FETCH_LAST.
- FETCH_LAST: ir_write=1; alu_src_a=0, alu_src_b=01, alu_op=ADD; pc_source=00, pc_write=1.
- DECODE: ab_load=1; alu_src_a=0, alu_src_b=11, alu_op=ADD, alu_out_load=1 (branch target).
- DECODE dispatches on opcode:
  - 0x00 -> EXEC_R
  - 0x08 -> EXEC_I
  - 0x23/0x2B -> ADDR
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - anything else -> FETCH_0 (no side effects)
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op from funct (0x20 ADD, 0x22 SUB, 0x24 AND, else ADD); alu_out_load=1 -> ALU_WB (reg_dst=1).
- EXEC_I: alu_src_a=1, alu_src_b=10, ADD, alu_out_load=1 -> ALU_WB (reg_dst=0).
- ALU_WB: reg_write=1, mem_to_reg=0, reg_dst held from execute type -> FETCH_0.
- ADDR: alu_src_a=1, alu_src_b=10, ADD, alu_out_load=1. Goes to MEM_RD (lw) or MEM_WR (sw).
- MEM_WR: i_or_d=1, mem_wr=1 for exactly one cycle -> FETCH_0.
- MEM_RD: i_or_d=1, waits MEM_WAIT cycles using the same counter. The last cycle asserts mdr_load=1 -> LW_WB.
- LW_WB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH_0.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB; pc_source=01; pc_write=zero -> FETCH_0.
- JUMP: pc_source=10, pc_write=1 -> FETCH_0.
- Cycle counts with MEM_WAIT=2: R/addi/sw 6, beq/j 5, lw 9.
- The wait counter is cleared on every state entry. It never wraps past MEM_WAIT-1.

Optional Feature:
OVERFLOW_EXC_EN
- Defined: in ALU_WB, for ADD/SUB R-type or addi, overflow=1 suppresses reg_write and moves to EXC. EXC asserts epc_write=1, pc_source=11, pc_write=1 for one cycle -> FETCH_0. Undefined opcodes also go to EXC.
- Undefined: overflow is ignored, epc_write is tied 0, and EXC does not exist.

Decomposition:
- Package ctrl_pkg holds:
  - state enum
  - opcode and funct constants
  - alu_op encodings
  - alu_src_b constants: SRC_B_REG=00, SRC_B_FOUR=01, SRC_B_SEXT=10, SRC_B_SEXT_SH2=11
  - pc_source encodings
- One sub-module, alu_op_decoder: combinational funct -> alu_op, used in EXEC_R.

Test Plan:
- reset=1 for 3 cycles mid-lw (in MEM_RD) -> all outputs 0 while reset is sampled, no reg_write; after release, FETCH_0 then ir_write exactly 3 cycles later.
- opcode=0x00, funct=0x22 -> DECODE with alu_src_b=11; EXEC_R with alu_src_b=00, alu_op=010; reg_write=1, reg_dst=1 on cycle 6; 6 cycles total.
- opcode=0x23 -> ADDR with alu_src_b=10; mdr_load on cycle 8; reg_write=1, mem_to_reg=1 on cycle 9.
- opcode=0x04: zero=1 -> pc_write=1, pc_source=01 in BRANCH; zero=0 -> pc_write=0; both take 5 cycles.
- opcode=0x3F -> DECODE then FETCH_0 with no reg_write, mem_wr or pc_write beyond fetch. With OVERFLOW_EXC_EN -> EXC with epc_write=1, pc_source=11.
- OVERFLOW_EXC_EN, opcode=0x08, overflow=1 in ALU_WB -> reg_write=0, next cycle epc_write=1 and pc_write=1. Without the macro -> reg_write=1, epc_write never asserts.
